mul8_seq: RTL and testbench

MUL8_SEQ -- requirements
Module: mul8_seq

---
 rtl/mul8_seq.sv | 159 +++++++++++++++
 tb/tb_mul8_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned multiplier: one 4x4 Wallace-tree multiplier reused over
// four partial-product cycles, with valid/ready handshakes on both sides.

module wallace_multiplier (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);

  // {carry, sum}
  function automatic logic [1:0] ha(input logic i0, input logic i1);
    return {i0 & i1, i0 ^ i1};
  endfunction

  function automatic logic [1:0] fa(input logic i0, input logic i1, input logic i2);
    return {(i0 & i1) | (i2 & (i0 ^ i1)), i0 ^ i1 ^ i2};
  endfunction

  logic [3:0] pp [4];
  logic [1:0] h1, f2, f3, f4, h5;
  logic [1:0] k2, k3, k4, k5, k6;
  logic [7:0] row_s, row_c;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp[i] = x & {4{y[i]}};
    end
  end

  // Reduction level 1: pp[i][j] carries weight i+j
  assign h1 = ha(pp[0][1], pp[1][0]);
  assign f2 = fa(pp[0][2], pp[1][1], pp[2][0]);
  assign f3 = fa(pp[0][3], pp[1][2], pp[2][1]);
  assign f4 = fa(pp[1][3], pp[2][2], pp[3][1]);
  assign h5 = ha(pp[2][3], pp[3][2]);

  // Reduction level 2: leaves at most two bits per column
  assign k2 = ha(h1[1], f2[0]);
  assign k3 = fa(f2[1], f3[0], pp[3][0]);
  assign k4 = ha(f3[1], f4[0]);
  assign k5 = ha(f4[1], h5[0]);
  assign k6 = ha(h5[1], pp[3][3]);

  assign row_s = {1'b0, k6[0], k5[0], k4[0], k3[0], k2[0], h1[0], pp[0][0]};
  assign row_c = {k6[1], k5[1], k4[1], k3[1], k2[1], 3'b000};

  assign p = row_s + row_c;

endmodule

module mul8_seq #(
  parameter int unsigned ZERO_SKIP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  localparam int DATA_W = 8;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PP0  = 3'd1;
  localparam logic [2:0] PP1  = 3'd2;
  localparam logic [2:0] PP2  = 3'd3;
  localparam logic [2:0] PP3  = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0]          state;
  logic [DATA_W-1:0]   a_r, b_r;
  logic [2*DATA_W-1:0] acc;
  logic [3:0]          mx, my;
  logic [7:0]          pp;
  logic [2*DATA_W-1:0] pp_sh;
  logic                zero_op;

  wallace_multiplier u_mul (
    .x (mx),
    .y (my),
    .p (pp)
  );

  // Nibble selection and weight of the partial product for the current cycle
  always_comb begin
    mx    = a_r[3:0];
    my    = b_r[3:0];
    pp_sh = {8'h00, pp};
    case (state)
      PP1: begin
        mx    = a_r[7:4];
        pp_sh = {4'h0, pp, 4'h0};
      end
      PP2: begin
        my    = b_r[7:4];
        pp_sh = {4'h0, pp, 4'h0};
      end
      PP3: begin
        mx    = a_r[7:4];
        my    = b_r[7:4];
        pp_sh = {pp, 8'h00};
      end
      default: ;
    endcase
  end

  assign zero_op = (ZERO_SKIP != 0) && ((a == '0) || (b == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            acc   <= '0;
            state <= zero_op ? DONE : PP0;
          end
        end
        PP0: begin
          acc   <= acc + pp_sh;
          state <= PP1;
        end
        PP1: begin
          acc   <= acc + pp_sh;
          state <= PP2;
        end
        PP2: begin
          acc   <= acc + pp_sh;
          state <= PP3;
        end
        PP3: begin
          acc   <= acc + pp_sh;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = acc;

endmodule

// File: tb/tb_mul8_seq.sv
// Randomized self-checking bench for mul8_seq; two instances cover ZERO_SKIP=1 and 0.

module tb_mul8_seq;

  logic        clk;
  logic        rst;
  logic        iv;
  logic [7:0]  ta, tb;
  logic        ordy;
  logic        sel;

  logic        zs_iv, nz_iv;
  logic        zs_ir, nz_ir, zs_ov, nz_ov, zs_busy, nz_busy;
  logic [15:0] zs_prod, nz_prod;

  logic        m_ir, m_ov, m_busy;
  logic [15:0] m_prod;

  int nchk  = 0;
  int nfail = 0;
  int issued  = 0;
  int results = 0;

  mul8_seq u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (zs_iv),
    .in_ready  (zs_ir),
    .a         (ta),
    .b         (tb),
    .out_valid (zs_ov),
    .out_ready (ordy),
    .product   (zs_prod),
    .busy      (zs_busy)
  );

  mul8_seq #(.ZERO_SKIP(0)) u_dut_nz (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (nz_iv),
    .in_ready  (nz_ir),
    .a         (ta),
    .b         (tb),
    .out_valid (nz_ov),
    .out_ready (ordy),
    .product   (nz_prod),
    .busy      (nz_busy)
  );

  // sel=0 drives the ZERO_SKIP=1 instance, sel=1 the ZERO_SKIP=0 instance
  assign zs_iv  = sel ? 1'b0 : iv;
  assign nz_iv  = sel ? iv : 1'b0;
  assign m_ir   = sel ? nz_ir   : zs_ir;
  assign m_ov   = sel ? nz_ov   : zs_ov;
  assign m_busy = sel ? nz_busy : zs_busy;
  assign m_prod = sel ? nz_prod : zs_prod;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    iv  = 1'b1;
    ordy = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  32'(zs_ir),   32'd1);
    check("rst_out_valid", 32'(zs_ov),   32'd0);
    check("rst_busy",      32'(zs_busy), 32'd0);
    check("rst_product",   32'(zs_prod), 32'd0);
    check("rst_nz_ready",  32'(nz_ir),   32'd1);
    check("rst_nz_prod",   32'(nz_prod), 32'd0);
    rst  = 1'b0;
    iv   = 1'b0;
    ordy = 1'b0;
  endtask

  // Called just after a negedge; issues one operation on the selected instance
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        input int stall, input bit scramble);
    int          lat;
    int          exp_lat;
    logic [15:0] exp;
    exp     = 16'(ia) * 16'(ib);
    exp_lat = (!sel && (ia == 8'h00 || ib == 8'h00)) ? 1 : 1 + 4;
    check("in_ready", 32'(m_ir), 32'd1);
    iv = 1'b1;
    ta = ia;
    tb = ib;
    ordy = 1'b0;
    @(negedge clk);
    issued++;
    iv  = scramble;
    lat = 1;
    while (!m_ov && lat < 20) begin
      check("busy", 32'(m_busy), 32'd1);
      check("in_ready_busy", 32'(m_ir), 32'd0);
      if (scramble) begin
        ta = 8'($urandom);
        tb = 8'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    if (!m_ov) begin
      iv = 1'b0;
      return;
    end
    check("product", 32'(m_prod), 32'(exp));
    check("busy_done", 32'(m_busy), 32'd1);
    for (int i = 0; i < stall; i++) begin
      if (scramble) begin
        ta = 8'($urandom);
        tb = 8'($urandom);
      end
      @(negedge clk);
      check("stall_valid", 32'(m_ov), 32'd1);
      check("stall_ready", 32'(m_ir), 32'd0);
      check("stall_prod",  32'(m_prod), 32'(exp));
    end
    ordy = 1'b1;
    @(negedge clk);
    results++;
    ordy = 1'b0;
    iv   = 1'b0;
    check("post_valid", 32'(m_ov), 32'd0);
    check("post_ready", 32'(m_ir), 32'd1);
    check("post_busy",  32'(m_busy), 32'd0);
    check("post_prod",  32'(m_prod), 32'(exp));
  endtask

  initial begin
    rst  = 1'b0;
    iv   = 1'b0;
    ta   = 8'h00;
    tb   = 8'h00;
    ordy = 1'b0;
    sel  = 1'b0;

    do_reset();
    run_op(8'hFF, 8'hFF, 0, 1'b0);
    run_op(8'h00, 8'h37, 0, 1'b0);
    run_op(8'h9C, 8'h2B, 3, 1'b0);

    sel = 1'b1;
    run_op(8'h00, 8'h37, 0, 1'b0);
    run_op(8'h37, 8'h00, 1, 1'b1);
    run_op(8'hFF, 8'hFF, 2, 1'b1);
    sel = 1'b0;

    // Reset while the selected instance sits in PP2
    @(negedge clk);
    iv = 1'b1;
    ta = 8'hA5;
    tb = 8'h5A;
    @(negedge clk);
    iv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_valid", 32'(zs_ov), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 32'(zs_ir),   32'd1);
    check("midrst_valid", 32'(zs_ov),   32'd0);
    check("midrst_prod",  32'(zs_prod), 32'd0);
    run_op(8'h12, 8'h34, 0, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 9) == 0) ra = 8'h00;
      if ($urandom_range(0, 9) == 0) rb = 8'h00;
      sel = ($urandom_range(0, 3) == 0);
      run_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom));
    end

    check("scoreboard", 32'(results), 32'(issued));
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
